mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter AW, default 8, word-address width; depth = 2^AW 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, edges from request sample to mem_ack rise; legal range 1..15.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port mem_read  in  1  read request from the PE controller.
REQ-006 SHALL have port mem_address  in  32  word address from the PE output, not byte address.
REQ-007 SHALL have port mem_ack  out  1  read-data-valid acknowledge, registered.
REQ-008 SHALL have port mem_Message  out  32  read data, registered.
REQ-009 SHALL have port init_we  in  1  backdoor word write enable for program/data preload.
REQ-010 SHALL have port init_addr  in  AW  backdoor write address.
REQ-011 SHALL have port init_data  in  32  backdoor write data.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port addr_err  out  1  sticky flag for an out-of-range request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK.
- IDLE: on an edge with mem_read=1, capture mem_address into addr_q, load cnt=LATENCY-1, go to WAIT.
REQ-015 SHALL handle WAIT on each edge as follows:
- mem_read=0: abort; go to IDLE with no ack and mem_Message unchanged.
- else cnt!=0: decrement cnt.
- else cnt==0: mem_ack<=1, mem_Message<=read data, go to ACK.
REQ-016 SHALL produce latency: request sampled at edge E0 -> mem_ack high after edge E0+LATENCY.
REQ-017 SHALL hold, in ACK, mem_ack=1 and mem_Message stable while mem_read=1; on the first edge with mem_read=0: mem_ack<=0, go to IDLE.
REQ-018 SHALL keep mem_Message holding its last value after mem_ack falls.
REQ-019 SHALL accept a new request only in IDLE, giving a minimum of one idle edge between requests (four-phase handshake).
REQ-020 SHALL use addr_q for the read; mem_address changes after capture SHALL be ignored.
REQ-021 SHALL treat addr_q[31:AW]!=0 as out of range:
- still complete the handshake with mem_Message=32'h0;
- set addr_err, which stays 1 until reset.
REQ-022 SHALL accept init_we in any state; it writes init_data to mem[init_addr] at the edge.
REQ-023 SHALL read-before-write when an init write and the ack-edge read address the same word on the same edge: mem_Message gets the old value.
REQ-024 SHALL leave memory contents unaffected by the read handshake.

Reset
REQ-025 SHALL, on an edge with rst_n=0, force state=IDLE, mem_ack=0, mem_Message=0, busy=0, addr_err=0, cnt=0, addr_q=0.
REQ-026 SHALL abort any WAIT/ACK when reset occurs mid-operation; no ack after reset release unless a new request is sampled.
REQ-027 SHALL NOT reset memory contents; init writes during reset are ignored.

Verification
REQ-028 Basic read, LATENCY=2: preload mem[5]=32'hDEADBEEF, assert mem_read with address 5 at E0, drop mem_read on seeing ack -> mem_ack high after E2, mem_Message=32'hDEADBEEF, mem_ack low one edge after mem_read low.
REQ-029 Held request: keep mem_read high 4 extra edges in ACK -> mem_ack and data stable all 4 edges; mem_address changed to 6 during WAIT -> data still from address 5.
REQ-030 Abort: drop mem_read after E1 with LATENCY=3 -> no ack ever, busy low after next edge; a subsequent request completes normally.
REQ-031 Out of range, AW=8: address 32'h100 -> ack after LATENCY edges, mem_Message=0, addr_err=1 and stays 1 through later good reads.
REQ-032 Collision: init write mem[5]=32'h1 on the ack edge of a read of address 5 (old value 32'h2) -> mem_Message=32'h2; next read returns 32'h1.
REQ-033 Reset mid-ACK: rst_n=0 for one edge while mem_ack=1 -> mem_ack=0, mem_Message=0, busy=0; memory preserved, verified by a re-read.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed read responder with a programmable ack latency and a backdoor
// preload port. Four-phase handshake: mem_read up -> mem_ack up -> mem_read down -> mem_ack down.
//
// state | meaning
// IDLE  | waiting for mem_read; only state that accepts a new request
// WAIT  | address captured, counting down to the ack edge
// ACK   | mem_ack high with data valid, waiting for mem_read to fall
module mem_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic [31:0]   mem_address,
  output logic          mem_ack,
  output logic [31:0]   mem_Message,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [31:0]   init_data,
  output logic          busy,
  output logic          addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic        ack_nxt;
  logic [31:0] msg_nxt;
  logic        err_nxt;
  logic        in_range;
  logic [31:0] read_word;

  logic [31:0] mem [2**AW];

  // Backdoor writes land at the edge; reads below see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst_n && init_we) begin
      mem[init_addr] <= init_data;
    end
  end

  assign in_range  = (addr_q >> AW) == 32'd0;
  assign read_word = in_range ? mem[addr_q[AW-1:0]] : 32'd0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    ack_nxt   = mem_ack;
    msg_nxt   = mem_Message;
    err_nxt   = addr_err;
    unique case (state)
      IDLE: begin
        if (mem_read) begin
          addr_nxt  = mem_address;
          cnt_nxt   = CNT_LOAD;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!mem_read) begin
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          ack_nxt   = 1'b1;
          msg_nxt   = read_word;
          err_nxt   = addr_err | ~in_range;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!mem_read) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= 32'd0;
      mem_ack     <= 1'b0;
      mem_Message <= 32'd0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      addr_q      <= addr_nxt;
      mem_ack     <= ack_nxt;
      mem_Message <= msg_nxt;
      addr_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 2 and 3) share one stimulus
// stream and are checked every cycle against an edge-counting handshake model.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [31:0] init_data;

  logic [1:0]  ack_d;
  logic [1:0]  busy_d;
  logic [1:0]  err_d;
  logic [31:0] msg_d [2];

  int vec  = 0;
  int miss = 0;
  bit cmp_en = 0;

  mem_responder #(.AW(8), .LATENCY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_address(mem_address),
    .mem_ack(ack_d[0]), .mem_Message(msg_d[0]), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .busy(busy_d[0]), .addr_err(err_d[0])
  );

  mem_responder #(.AW(8), .LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_address(mem_address),
    .mem_ack(ack_d[1]), .mem_Message(msg_d[1]), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .busy(busy_d[1]), .addr_err(err_d[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 request pending (el = edges since sample), 2 acked.
  int          lat [2] = '{2, 3};
  int          ph  [2] = '{0, 0};
  int          el  [2] = '{0, 0};
  logic [31:0] a_m [2];
  logic        ack_m [2] = '{1'b0, 1'b0};
  logic [31:0] msg_m [2] = '{32'd0, 32'd0};
  logic        err_m [2] = '{1'b0, 1'b0};
  logic [31:0] mem_m [256];

  initial begin
    for (int k = 0; k < 256; k++) mem_m[k] = 32'd0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          ph[i] = 0; ack_m[i] = 1'b0; msg_m[i] = 32'd0; err_m[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          case (ph[i])
            0: if (mem_read) begin ph[i] = 1; el[i] = 0; a_m[i] = mem_address; end
            1: begin
              if (!mem_read) ph[i] = 0;
              else begin
                el[i]++;
                if (el[i] == lat[i]) begin
                  ph[i] = 2;
                  ack_m[i] = 1'b1;
                  if (a_m[i] < 32'd256) msg_m[i] = mem_m[a_m[i][7:0]];
                  else begin msg_m[i] = 32'd0; err_m[i] = 1'b1; end
                end
              end
            end
            default: if (!mem_read) begin ph[i] = 0; ack_m[i] = 1'b0; end
          endcase
        end
        if (init_we) mem_m[init_addr] = init_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("model_ack%0d", i), 32'(ack_d[i]), 32'(ack_m[i]));
          chk($sformatf("model_msg%0d", i), msg_d[i], msg_m[i]);
          chk($sformatf("model_busy%0d", i), 32'(busy_d[i]), 32'(ph[i] != 0));
          chk($sformatf("model_err%0d", i), 32'(err_d[i]), 32'(err_m[i]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    step(1);
    init_we = 1'b0;
  endtask

  task automatic wait_ack_b();
    int n = 0;
    do begin step(1); n++; end while (!ack_d[1] && n < 20);
    chk("ack_seen", 32'(ack_d[1]), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
    mem_read = 1'b1; mem_address = a;
    wait_ack_b();
    chk("rd_msg_a", msg_d[0], exp);
    chk("rd_msg_b", msg_d[1], exp);
    mem_read = 1'b0;
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_address = 32'd0;
    init_we = 1'b0; init_addr = 8'd0; init_data = 32'd0;
    step(2);
    rst_n = 1'b1; cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", 32'(ack_d[i]), 32'd0);
      chk("rst_msg", msg_d[i], 32'd0);
      chk("rst_busy", 32'(busy_d[i]), 32'd0);
      chk("rst_err", 32'(err_d[i]), 32'd0);
    end
    wr(8'd5, 32'hDEADBEEF);
    wr(8'd9, 32'h0000_0011);
    step(1);

    // Basic read, hand-timed against the LATENCY=2 instance
    mem_read = 1'b1; mem_address = 32'd5;
    step(1);
    chk("basic_busy_e0", 32'(busy_d[0]), 32'd1);
    chk("basic_ack_e0", 32'(ack_d[0]), 32'd0);
    step(1);
    chk("basic_ack_e1", 32'(ack_d[0]), 32'd0);
    step(1);
    chk("basic_ack_e2", 32'(ack_d[0]), 32'd1);
    chk("basic_msg_e2", msg_d[0], 32'hDEADBEEF);
    mem_read = 1'b0;
    step(1);
    chk("basic_ack_drop", 32'(ack_d[0]), 32'd0);
    chk("basic_msg_hold", msg_d[0], 32'hDEADBEEF);
    step(1);

    // Held request with address change during WAIT
    mem_read = 1'b1; mem_address = 32'd5;
    step(1);
    mem_address = 32'd6;
    wait_ack_b();
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("hold_ack_a", 32'(ack_d[0]), 32'd1);
      chk("hold_ack_b", 32'(ack_d[1]), 32'd1);
      chk("hold_msg_b", msg_d[1], 32'hDEADBEEF);
    end
    mem_read = 1'b0;
    step(2);

    // Abort after E1
    mem_read = 1'b1; mem_address = 32'd9;
    step(2);
    mem_read = 1'b0;
    step(1);
    chk("abort_busy_b", 32'(busy_d[1]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_ack_b", 32'(ack_d[1]), 32'd0);
      step(1);
    end
    do_read(32'd9, 32'h0000_0011);

    // Out of range, then a good read with the sticky flag
    do_read(32'h100, 32'd0);
    chk("oor_err_a", 32'(err_d[0]), 32'd1);
    chk("oor_err_b", 32'(err_d[1]), 32'd1);
    do_read(32'd5, 32'hDEADBEEF);
    chk("oor_sticky_b", 32'(err_d[1]), 32'd1);

    // Collision on the LATENCY=3 ack edge
    wr(8'd5, 32'h0000_0002);
    mem_read = 1'b1; mem_address = 32'd5;
    step(3);
    init_we = 1'b1; init_addr = 8'd5; init_data = 32'h0000_0001;
    step(1);
    init_we = 1'b0;
    chk("coll_ack_b", 32'(ack_d[1]), 32'd1);
    chk("coll_msg_b", msg_d[1], 32'h0000_0002);
    mem_read = 1'b0;
    step(2);
    do_read(32'd5, 32'h0000_0001);

    // Reset while acked; write during reset must be dropped
    mem_read = 1'b1; mem_address = 32'd9;
    wait_ack_b();
    rst_n = 1'b0; mem_read = 1'b0;
    init_we = 1'b1; init_addr = 8'd9; init_data = 32'h0000_0BAD;
    step(1);
    rst_n = 1'b1; init_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mrst_ack", 32'(ack_d[i]), 32'd0);
      chk("mrst_msg", msg_d[i], 32'd0);
      chk("mrst_busy", 32'(busy_d[i]), 32'd0);
      chk("mrst_err", 32'(err_d[i]), 32'd0);
    end
    step(3);
    do_read(32'd9, 32'h0000_0011);
    do_read(32'd5, 32'h0000_0001);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
